// File: rtl/display_pkg.sv
// Shared constants for the 7-segment scan multiplexer: state encoding,
// segment bit positions and the all-dark segment pattern.
package display_pkg;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SHOW  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  localparam int DISP_N_DEFAULT = 3;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-DIV cycle counter: counts 0..DIV-1 while enabled, wraps on terminal
// count, and is forced to zero by a synchronous clear.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = clog2_min1(DIV);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) cnt_q <= cnt_d;

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed common-anode 7-segment driver; oFrame marks the LOAD cycle.
// Optional inter-digit blanking is enabled by defining SCAN_BLANK_EN.
module display_scan
  import display_pkg::*;
#(
  parameter int N_DISP   = DISP_N_DEFAULT,
  parameter int SCAN_DIV = 50000
`ifdef SCAN_BLANK_EN
  , parameter int BLANK_CYCLES = 16
`endif
) (
  input  logic                              pulso,
  input  logic                              rst,
  input  logic [N_DISP-1:0]                 iSegA,
  input  logic [N_DISP-1:0]                 iSegB,
  input  logic [N_DISP-1:0]                 iSegC,
  input  logic [N_DISP-1:0]                 iSegD,
  input  logic [N_DISP-1:0]                 iSegE,
  input  logic [N_DISP-1:0]                 iSegF,
  input  logic [N_DISP-1:0]                 iSegG,
  output logic [N_DISP-1:0]                 oAn,
  output logic [6:0]                        oSeg,
  output logic [clog2_min1(N_DISP)-1:0]     oDigit,
  output logic                              oFrame
);

  localparam int IW = clog2_min1(N_DISP);
  localparam logic [IW-1:0] LAST = IW'(N_DISP - 1);

  logic [1:0]                 state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [6:0][N_DISP-1:0]     shadow_q, shadow_d;
  logic                       div_tc;
  logic                       blank_tc;

  scan_prescaler #(.DIV(SCAN_DIV)) u_div (
    .clk_i (pulso),
    .clr_i (rst || (state_q == S_LOAD)),
    .en_i  (state_q == S_SHOW),
    .tc_o  (div_tc)
  );

`ifdef SCAN_BLANK_EN
  scan_prescaler #(.DIV(BLANK_CYCLES)) u_blank (
    .clk_i (pulso),
    .clr_i (rst),
    .en_i  (state_q == S_BLANK),
    .tc_o  (blank_tc)
  );
`else
  assign blank_tc = 1'b0;
`endif

  // Inputs are only sampled in LOAD so a frame never mixes two input sets.
  always_comb begin
    shadow_d = shadow_q;
    if (state_q == S_LOAD) begin
      shadow_d[SEG_A] = iSegA;
      shadow_d[SEG_B] = iSegB;
      shadow_d[SEG_C] = iSegC;
      shadow_d[SEG_D] = iSegD;
      shadow_d[SEG_E] = iSegE;
      shadow_d[SEG_F] = iSegF;
      shadow_d[SEG_G] = iSegG;
    end
  end

  always_ff @(posedge pulso) begin
    if (rst) begin
      state_q  <= S_LOAD;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_LOAD: begin
        state_d = S_SHOW;
        idx_d   = '0;
      end
      S_SHOW: begin
        if (div_tc) begin
          if (idx_q == LAST) begin
            state_d = S_LOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
`ifdef SCAN_BLANK_EN
            state_d = S_BLANK;
`endif
          end
        end
      end
      S_BLANK: begin
        if (blank_tc) state_d = S_SHOW;
      end
      default: begin
        state_d = S_LOAD;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    oAn    = '1;
    oSeg   = SEG_OFF;
    oDigit = idx_q;
    oFrame = (state_q == S_LOAD);
    if (state_q == S_SHOW) begin
      oAn = ~(N_DISP'(1) << idx_q);
      for (int s = 0; s < 7; s++) oSeg[s] = ~shadow_q[s][idx_q];
    end
  end

endmodule
